// File: rtl/poly_sched_pkg.sv
// rtl/poly_sched_pkg.sv - shared widths, FSM encoding and coefficient helper for poly_sched
package poly_sched_pkg;

  localparam int OP_W   = 4;
  localparam int RES_W  = 18;
  localparam int COEF_W = 6;
  localparam int PROD_W = RES_W + OP_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STEP = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic signed [RES_W-1:0] sext_coef(input logic signed [COEF_W-1:0] c);
    return {{(RES_W-COEF_W){c[COEF_W-1]}}, c};
  endfunction

endpackage

// File: rtl/poly_sched_rr_arb2.sv
// rtl/poly_sched_rr_arb2.sv - two-way round-robin arbiter; pointer moves past the winner on advance
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       adv_i,
  output logic [1:0] gnt_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt_o = req_i;
    if (&req_i) gnt_o = ptr_q ? 2'b10 : 2'b01;
    ptr_d = ptr_q;
    // Winner 0 hands priority to 1 and vice versa.
    if (adv_i && (|req_i)) ptr_d = gnt_o[0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/poly_sched.sv
// rtl/poly_sched.sv - two-requester cubic evaluator, Horner form, one 18x4 multiply per STEP cycle
module poly_sched #(
  parameter logic signed [poly_sched_pkg::COEF_W-1:0] A3 = 6'sd3,
  parameter logic signed [poly_sched_pkg::COEF_W-1:0] A2 = -6'sd2,
  parameter logic signed [poly_sched_pkg::COEF_W-1:0] A1 = 6'sd1,
  parameter logic signed [poly_sched_pkg::COEF_W-1:0] A0 = 6'sd5
) (
  input  logic                                      CLK,
  input  logic                                      RST,
  input  logic                                      REQ0,
  input  logic signed [poly_sched_pkg::OP_W-1:0]    X0,
  input  logic                                      REQ1,
  input  logic signed [poly_sched_pkg::OP_W-1:0]    X1,
  output logic [1:0]                                GNT,
  output logic                                      BUSY,
  output logic                                      VALID,
  output logic                                      ID,
  output logic signed [poly_sched_pkg::RES_W-1:0]   outR
);
  import poly_sched_pkg::*;

  state_e                   state_q, state_d;
  logic signed [OP_W-1:0]   x_q, x_d;
  logic signed [RES_W-1:0]  acc_q, acc_d;
  logic signed [RES_W-1:0]  out_q, out_d;
  logic signed [RES_W-1:0]  coef;
  logic signed [PROD_W-1:0] prod;
  logic [1:0]               cnt_q, cnt_d;
  logic [1:0]               gnt_q, gnt_d;
  logic [1:0]               arb_gnt;
  logic                     own_q, own_d;
  logic                     id_q, id_d;
  logic                     adv;

  assign adv = (state_q == ST_IDLE) && (REQ0 || REQ1);

  rr_arb2 u_arb (
    .clk_i (CLK),
    .rst_i (RST),
    .req_i ({REQ1, REQ0}),
    .adv_i (adv),
    .gnt_o (arb_gnt)
  );

  always_comb begin
    case (cnt_q)
      2'd2:    coef = sext_coef(A2);
      2'd1:    coef = sext_coef(A1);
      default: coef = sext_coef(A0);
    endcase
  end

  // Full-width signed product; the coefficient ranges keep the result inside 18 bits.
  assign prod = PROD_W'(acc_q) * PROD_W'(x_q);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    gnt_d   = 2'b00;
    own_d   = own_q;
    out_d   = out_q;
    id_d    = id_q;
    case (state_q)
      ST_IDLE: begin
        if (adv) begin
          state_d = ST_STEP;
          own_d   = arb_gnt[1];
          x_d     = arb_gnt[1] ? X1 : X0;
          acc_d   = sext_coef(A3);
          cnt_d   = 2'd2;
          gnt_d   = arb_gnt;
        end
      end
      ST_STEP: begin
        acc_d = RES_W'(prod) + coef;
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd0) begin
          state_d = ST_DONE;
          out_d   = acc_d;
          id_d    = own_q;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= 2'd0;
      gnt_q   <= 2'b00;
      own_q   <= 1'b0;
      out_q   <= '0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      own_q   <= own_d;
      out_q   <= out_d;
      id_q    <= id_d;
    end
  end

  assign GNT   = gnt_q;
  assign BUSY  = (state_q != ST_IDLE);
  assign VALID = (state_q == ST_DONE);
  assign ID    = id_q;
  assign outR  = out_q;

endmodule

// File: doc/poly_sched.md
POLY_SCHED -- requirements
Module: poly_sched

Interface
REQ-001 Parameter A3, default 3, signed 6-bit cubic coefficient.
REQ-002 Parameter A2, default -2, signed 6-bit square coefficient.
REQ-003 Parameter A1, default 1, signed 6-bit linear coefficient.
REQ-004 Parameter A0, default 5, signed 6-bit constant term.
REQ-005 CLK  input  1  single clock; all state updates on its rising edge.
REQ-006 RST  input  1  reset, synchronous, active-high.
REQ-007 REQ0  input  1  requester 0 request; level, held until GNT[0].
REQ-008 X0  input  4  requester 0 operand, signed.
REQ-009 REQ1  input  1  requester 1 request; level, held until GNT[1].
REQ-010 X1  input  4  requester 1 operand, signed.
REQ-011 GNT  output  2  one-hot, one-cycle pulse; operand of that requester captured.
REQ-012 BUSY  output  1  high whenever the FSM is not in IDLE.
REQ-013 VALID  output  1  one-cycle pulse; outR and ID carry a new result.
REQ-014 ID  output  1  index of the requester owning the current result.
REQ-015 outR  output  18  signed result A3*X^3 + A2*X^2 + A1*X + A0.

Function
REQ-016 The FSM SHALL have states IDLE, STEP, DONE; IDLE->STEP on any sampled request, STEP->DONE after the third STEP cycle, DONE->IDLE unconditionally.
REQ-017 In IDLE with a request, the winner's X SHALL be latched, acc loaded with A3, step counter set to 2, and GNT[winner] asserted in the following cycle (first STEP cycle).
REQ-018 Each STEP cycle SHALL perform acc <= acc*Xlatched + A[k] for k = 2, 1, 0 in that order (Horner); exactly one multiply per cycle.
REQ-019 The product SHALL be formed at full signed width and truncated to 18 bits; the parameter ranges guarantee no overflow (|result| < 2^17).
REQ-020 In DONE, outR SHALL be acc, ID the owner, and VALID high for exactly that cycle.
REQ-021 Latency: request sampled in cycle t -> GNT at t+1 -> VALID at t+4 -> next request accepted no earlier than t+5.
REQ-022 Arbitration SHALL be round-robin: one requester -> it wins; both -> requester named by the priority pointer wins; the pointer then moves to the other requester.
REQ-023 Requests arriving while BUSY SHALL be neither granted nor lost; they are served at the next IDLE cycle if still held.
REQ-024 Changes on X0/X1 after the grant SHALL NOT affect the result in progress.
REQ-025 outR and ID SHALL hold their last value between VALID pulses.

Reset
REQ-026 RST SHALL force, on the next edge: state IDLE, GNT 0, BUSY 0, VALID 0, ID 0, outR 0, acc 0, priority pointer to requester 0.
REQ-027 RST asserted mid-computation SHALL abort it with no VALID and no GNT pulse; the aborted request is re-arbitrated if still held.
REQ-028 RST SHALL take precedence over every simultaneous request.

Structure
REQ-029 A shared package SHALL hold the state encoding, operand width (4), result width (18) and coefficient width (6).
REQ-030 Two-way round-robin arbitration SHALL be a sub-module rr_arb2 (inputs request pair, advance strobe; output one-hot grant).
REQ-031 The datapath (one 18x4 signed multiplier, one adder, acc register) SHALL stay in poly_sched.

Verification
REQ-032 Default coefficients, REQ0 with X0 = 0, -1, -2, 3 in sequence -> outR = 5, -1, -29, 71, ID 0, each VALID four cycles after the sampled request.
REQ-033 X0 = -8 -> outR = -1667 (extreme-magnitude operand, no wrap).
REQ-034 REQ0 and REQ1 held together from reset, X0 = 3, X1 = -2 -> GNT order 0,1,0,1; results 71 (ID 0), -29 (ID 1) alternating.
REQ-035 REQ1 raised during a busy REQ0 job -> GNT[1] no earlier than the cycle after DONE; REQ0 result unchanged.
REQ-036 RST pulsed during second STEP cycle -> no VALID, all outputs 0 next cycle; held REQ0 re-granted and completes correctly.
REQ-037 X0 changed on the cycle after GNT[0] -> result reflects the captured operand.
